// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential 32-iteration MULT/MULTU/DIV/DIVU unit owning HI/LO
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       md_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed, op_div;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH:0]     div_cand, div_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new, quo, rem;

    always_comb begin
        op_signed = md_op_i[0];
        op_div    = md_op_i[1];
        mag_a     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

        // Shift-add: low half holds the remaining multiplier bits.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: upper half is the partial remainder.
        div_cand = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_cand - {1'b0, opnd_q};
        q_bit    = ~div_diff[WIDTH];
        rem_new  = q_bit ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], q_bit};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_BUSY;
                    count_d    = '0;
                    is_div_d   = op_div;
                    opnd_d     = op_div ? mag_b : mag_a;
                    acc_d      = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                    neg_res_d  = op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_rem_d  = op_signed && a_i[WIDTH-1];
                    div_zero_d = 1'b0;
                end else begin
                    if (wr_hi_i) hi_d = a_i;
                    if (wr_lo_i) lo_d = a_i;
                end
            end
            S_BUSY: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                div_zero_d = is_div_q && (opnd_q == '0);
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy_o     = (state_q == S_BUSY);
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] a_in, b_in;
    logic        wr_hi, wr_lo;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst), .start_i(start), .md_op_i(md_op),
        .a_i(a_in), .b_i(b_in), .wr_hi_i(wr_hi), .wr_lo_i(wr_lo),
        .busy_o(busy), .done_o(done), .div_zero_o(div_zero),
        .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launches one operation and watches 45 cycles; inputs are scrambled after start.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, output int lat, output int busy_cnt,
                          output int dones, output int overlaps, output logic dz_start,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output logic r_dz);
        @(negedge clk);
        md_op = op; a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = b ^ 32'h5A5A_5A5A; md_op = ~op;
        lat = -1; busy_cnt = 0; dones = 0; overlaps = 0; dz_start = div_zero;
        r_hi = 'x; r_lo = 'x; r_dz = 1'bx;
        for (int k = 0; k < 45; k++) begin
            if (busy) busy_cnt++;
            if (busy && done) overlaps++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = k; r_hi = hi; r_lo = lo; r_dz = div_zero;
                end
            end
            start = (k == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int lat, bc, nd, ov, cnt;
    logic dzs, rdz;
    logic [31:0] rhi, rlo;

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4]  = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'h0000_0001, 1'b1};
        vecs[6]  = '{2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{2'b00, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 1'b0};
        vecs[10] = '{2'b01, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; md_op = 2'b00; a_in = '0; b_in = '0; wr_hi = 1'b0; wr_lo = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_dz", 64'(div_zero), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        rst = 1'b0;

        a_in = 32'hCAFE_BABE; wr_hi = 1'b1;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi", 64'(hi), 64'hCAFE_BABE);
        a_in = 32'h1357_9BDF; wr_lo = 1'b1;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo", 64'(lo), 64'h1357_9BDF);

        md_op = 2'b00; a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(cnt), 64'(0));

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, bc, nd, ov, dzs, rhi, rlo, rdz);
            chk($sformatf("v%0d_hi", i), 64'(rhi), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(rlo), 64'(vecs[i].lo));
            chk($sformatf("v%0d_dz", i), 64'(rdz), 64'(vecs[i].dz));
            chk($sformatf("v%0d_dz_clear", i), 64'(dzs), 64'(0));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(33));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(32));
            chk($sformatf("v%0d_done_pulses", i), 64'(nd), 64'(1));
            chk($sformatf("v%0d_busy_done_overlap", i), 64'(ov), 64'(0));
        end

        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5, lat, bc, nd, ov, dzs, rhi, rlo, rdz);
        chk("ovf_hi", 64'(rhi), 64'(0));
        chk("ovf_lo", 64'(rlo), 64'h8000_0000);
        chk("ovf_latency", 64'(lat), 64'(33));
        chk("ovf_single_done", 64'(nd), 64'(1));

        @(negedge clk);
        md_op = 2'b00; a_in = 32'd3; b_in = 32'd5; start = 1'b1; wr_lo = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_beats_mtlo", 64'(lo), 64'h8000_0000);
        a_in = 32'h5555_5555;
        repeat (3) @(negedge clk);
        chk("busy_during_mtlo", 64'(busy), 64'(1));
        chk("mtlo_ignored_busy", 64'(lo), 64'h8000_0000);
        wr_lo = 1'b0;
        cnt = 0;
        while (!done && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("mtlo_seq_done_seen", 64'(done), 64'(1));
        chk("mtlo_seq_lo", 64'(lo), 64'(15));
        chk("mtlo_seq_hi", 64'(hi), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
